ga_generation_controller: RTL and testbench
===========================================

Name: ga_generation_controller

Overview:
Top-level sequencer for one GA run over the 10-path selected / 50-path mutant population datapath. Per generation it steps the fitness, selection and mutation stages in that order, each through a one-cycle start pulse and a done handshake. It then commits the mutant population back into the population register. It owns the 32-bit PRG seed shared by all stages, counts generations, and aborts to an error state if a stage stalls.

Parameters:
NUM_GENERATIONS, 100, generations per run; must be at least 1
GEN_W, 16, width of the generation counter
STAGE_TIMEOUT, 4095, maximum cycles to wait for a stage done before error
TO_W, 12, width of the timeout counter; must hold STAGE_TIMEOUT

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
run  in  1  start a run; sampled only in IDLE or DONE
abort  in  1  return to IDLE from any state
seed_in  in  32  initial PRG seed, captured when run is accepted
fit_start  out  1  one-cycle start pulse to the fitness stage
fit_done  in  1  fitness stage complete (pulse or level)
sel_start  out  1  one-cycle start pulse to the selection stage
sel_done  in  1  selection stage complete
mut_start  out  1  one-cycle start pulse to the mutation stage
mut_done  in  1  mutation stage complete
pop_load  out  1  one-cycle enable: population register loads mutant_pop
prg_seed  out  32  seed to all stages; stable while a stage runs
generation  out  GEN_W  count of completed generations in the current run
busy  out  1  high in FIT, SEL, MUT and COMMIT
done  out  1  high while in DONE
error  out  1  high while in ERR

Behaviour:
- Reset values: state=IDLE; all start pulses, pop_load, busy, done and error are 0; generation=0; prg_seed=32'h00000001; timeout counter=0.
- All outputs are registered or decoded directly from state. There are no combinational paths from inputs to outputs.
- States and transitions:
  - IDLE: on run go to FIT. Load prg_seed from seed_in, or 32'h1 if seed_in==0. Clear generation.
  - FIT: the matching start pulse is high only in the first cycle of the state. The done input is ignored in that first cycle and sampled from the second cycle on. Done goes to SEL.
  - SEL: same start/done rules as FIT. Done goes to MUT.
  - MUT: same start/done rules as FIT. Done goes to COMMIT.
  - COMMIT: lasts one cycle. pop_load=1. generation increments. prg_seed advances one step of a Galois LFSR with x^32+x^22+x^2+x+1 (mask 32'h80200003, shift right, XOR mask when the shifted-out bit is 1). If the new generation equals NUM_GENERATIONS, go to DONE; otherwise go to FIT.
  - DONE: done=1 and generation holds its final value. run starts a new run exactly as from IDLE.
  - ERR: error=1. Exit only through run (behaves as from IDLE), abort (go to IDLE) or reset.
- Latency:
  - run accepted in cycle N gives fit_start in cycle N+1.
  - A stage done sampled in cycle M gives the next start in cycle M+1.
  - mut_done in cycle M gives pop_load in cycle M+1 and the next fit_start in M+2.
- Timeout:
  - The counter clears on entry to each stage and increments every cycle in that stage.
  - If it reaches STAGE_TIMEOUT with no done seen, go to ERR on the next edge.
  - If done and timeout occur in the same cycle, done wins.
- Abort:
  - Highest priority: from any state other than IDLE, go to IDLE on the next edge.
  - No pop_load is issued. generation and prg_seed keep their values until the next run.
  - abort and run in the same cycle: abort wins.
- run while busy is ignored. Stage done inputs outside their own stage are ignored.
- The generation counter saturates at 2^GEN_W-1; it is only reachable if NUM_GENERATIONS exceeds that.
- Asserting rst_n low mid-run forces the reset values immediately, even while a start pulse is high.

Decomposition:
- Shared package ga_pkg holds:
  - state encoding localparams (IDLE=0, FIT, SEL, MUT, COMMIT, DONE, ERR);
  - LFSR mask 32'h80200003 and seed-zero substitute 32'h1;
  - datapath constants PATH_W=150, SEL_PATHS=10, POP_PATHS=50.
- One sub-module, ga_lfsr32: combinational single-step function, 32-bit in to 32-bit out, reused by the stage iterators.

Test Plan:
- Happy path: NUM_GENERATIONS=3, seed_in=32'h0000ACE1, each done returned 5 cycles after its start. Expect the order fit, sel, mut, pop_load repeated 3 times. generation steps 1, 2, 3. done rises the cycle after the third pop_load. prg_seed follows the LFSR sequence from 32'h0000ACE1, stepping once per commit.
- Zero seed: run with seed_in=0 -> prg_seed=32'h00000001 from the cycle after run.
- Stall: STAGE_TIMEOUT=16 and sel_done held low -> error=1 exactly 16 cycles after sel_start, with no mut_start. A following run restarts with generation=0.
- Abort during MUT: the next cycle is IDLE, with no pop_load and generation unchanged. mut_done arriving later is ignored.
- Early and stray done: fit_done high in the same cycle as fit_start is ignored. mut_done pulsed during FIT is ignored. run pulsed while busy causes no restart.
- Reset mid-run: rst_n low asynchronously while sel_start is high -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared GA definitions: controller state encoding, PRG constants and
// population datapath dimensions used across the GA stages.
package ga_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIT    = 3'd1,
    SEL    = 3'd2,
    MUT    = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } ga_state_e;

  // Galois taps for x^32+x^22+x^2+x+1, shift-right form
  localparam logic [31:0] LFSR_MASK     = 32'h80200003;
  localparam logic [31:0] SEED_ZERO_SUB = 32'h00000001;

  localparam int unsigned PATH_W    = 150;
  localparam int unsigned SEL_PATHS = 10;
  localparam int unsigned POP_PATHS = 50;

endpackage

// File: rtl/ga_generation_controller_if.sv
// Control/handshake bundle between the GA generation controller (master)
// and the stage datapath / host environment (slave).
interface ga_generation_controller_if #(
  parameter int unsigned GEN_W = 16
);
  logic             run;
  logic             abort;
  logic [31:0]      seed_in;
  logic             fit_start;
  logic             fit_done;
  logic             sel_start;
  logic             sel_done;
  logic             mut_start;
  logic             mut_done;
  logic             pop_load;
  logic [31:0]      prg_seed;
  logic [GEN_W-1:0] generation;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    input  run, abort, seed_in, fit_done, sel_done, mut_done,
    output fit_start, sel_start, mut_start, pop_load,
           prg_seed, generation, busy, done, error
  );

  modport slave (
    output run, abort, seed_in, fit_done, sel_done, mut_done,
    input  fit_start, sel_start, mut_start, pop_load,
           prg_seed, generation, busy, done, error
  );
endinterface

// File: rtl/ga_lfsr32.sv
// Single combinational step of the shared 32-bit Galois PRG.
module ga_lfsr32
  import ga_pkg::*;
(
  input  logic [31:0] state_i,
  output logic [31:0] state_o
);

  always_comb begin
    state_o = state_i >> 1;
    if (state_i[0]) state_o = state_o ^ LFSR_MASK;
  end

endmodule

// File: rtl/ga_generation_controller.sv
// GA run sequencer: steps fitness, selection and mutation each generation,
// commits the mutant population and advances the shared PRG seed.
module ga_generation_controller
  import ga_pkg::*;
#(
  parameter int unsigned NUM_GENERATIONS = 100,
  parameter int unsigned GEN_W           = 16,
  parameter int unsigned STAGE_TIMEOUT   = 4095,
  parameter int unsigned TO_W            = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ga_generation_controller_if.master bus
);

  ga_state_e        state_q, state_d;
  logic             fit_start_q, fit_start_d;
  logic             sel_start_q, sel_start_d;
  logic             mut_start_q, mut_start_d;
  logic             pop_load_q, pop_load_d;
  logic [GEN_W-1:0] gen_q, gen_d, gen_inc;
  logic [31:0]      seed_q, seed_d, seed_step;
  logic [TO_W-1:0]  to_q, to_d;
  logic             stage_first;
  logic             to_expired;
  logic             stage_d;

  ga_lfsr32 u_lfsr (
    .state_i (seed_q),
    .state_o (seed_step)
  );

  always_comb begin
    state_d     = state_q;
    gen_d       = gen_q;
    seed_d      = seed_q;
    // A start pulse is high exactly in the first cycle of its stage
    stage_first = fit_start_q | sel_start_q | mut_start_q;
    to_expired  = (to_q == TO_W'(STAGE_TIMEOUT - 1));
    gen_inc     = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);

    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.run) begin
          state_d = FIT;
          seed_d  = (bus.seed_in == '0) ? SEED_ZERO_SUB : bus.seed_in;
          gen_d   = '0;
        end
      end
      FIT: begin
        if (!stage_first && bus.fit_done) state_d = SEL;
        else if (to_expired)              state_d = ERR;
      end
      SEL: begin
        if (!stage_first && bus.sel_done) state_d = MUT;
        else if (to_expired)              state_d = ERR;
      end
      MUT: begin
        if (!stage_first && bus.mut_done) state_d = COMMIT;
        else if (to_expired)              state_d = ERR;
      end
      COMMIT: begin
        gen_d   = gen_inc;
        seed_d  = seed_step;
        state_d = (32'(gen_inc) == NUM_GENERATIONS) ? DONE : FIT;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle run or commit update
    if (bus.abort) begin
      state_d = IDLE;
      gen_d   = gen_q;
      seed_d  = seed_q;
    end

    stage_d     = (state_d == FIT) || (state_d == SEL) || (state_d == MUT);
    fit_start_d = (state_d == FIT) && (state_q != FIT);
    sel_start_d = (state_d == SEL) && (state_q != SEL);
    mut_start_d = (state_d == MUT) && (state_q != MUT);
    pop_load_d  = (state_d == COMMIT);

    if (!stage_d || (state_d != state_q)) to_d = '0;
    else                                  to_d = to_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fit_start_q <= 1'b0;
      sel_start_q <= 1'b0;
      mut_start_q <= 1'b0;
      pop_load_q  <= 1'b0;
      gen_q       <= '0;
      seed_q      <= SEED_ZERO_SUB;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      fit_start_q <= fit_start_d;
      sel_start_q <= sel_start_d;
      mut_start_q <= mut_start_d;
      pop_load_q  <= pop_load_d;
      gen_q       <= gen_d;
      seed_q      <= seed_d;
      to_q        <= to_d;
    end
  end

  assign bus.fit_start  = fit_start_q;
  assign bus.sel_start  = sel_start_q;
  assign bus.mut_start  = mut_start_q;
  assign bus.pop_load   = pop_load_q;
  assign bus.prg_seed   = seed_q;
  assign bus.generation = gen_q;
  assign bus.busy       = (state_q == FIT) || (state_q == SEL) ||
                          (state_q == MUT) || (state_q == COMMIT);
  assign bus.done       = (state_q == DONE);
  assign bus.error      = (state_q == ERR);

endmodule

// File: tb/tb_ga_generation_controller.sv
// Directed + randomized bench for the GA generation controller with a
// cycle-level reference model of stage timing, generation count and PRG seed.
module tb_ga_generation_controller;

  localparam int unsigned NG = 3;
  localparam int unsigned GW = 16;
  localparam int unsigned TO = 16;
  localparam int unsigned TW = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ga_generation_controller_if #(.GEN_W(GW)) bus ();

  ga_generation_controller #(
    .NUM_GENERATIONS (NG),
    .GEN_W           (GW),
    .STAGE_TIMEOUT   (TO),
    .TO_W            (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mseed;
  int          mgen;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic lsb;
    lsb = s[0];
    s   = s >> 1;
    if (lsb) s = s ^ 32'h80200003;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic start_of(input int st);
    case (st)
      0:       return bus.fit_start;
      1:       return bus.sel_start;
      default: return bus.mut_start;
    endcase
  endfunction

  function automatic logic next_of(input int st);
    case (st)
      0:       return bus.sel_start;
      1:       return bus.mut_start;
      default: return bus.pop_load;
    endcase
  endfunction

  task automatic set_done(input int st, input logic v);
    case (st)
      0:       bus.fit_done = v;
      1:       bus.sel_done = v;
      default: bus.mut_done = v;
    endcase
  endtask

  // Entered in the start cycle S of stage st; done is driven in cycle S+d.
  task automatic stage(input int st, input int d, input bit noisy);
    chk("start_pulse", start_of(st), 1);
    chk("seed_stable", bus.prg_seed, mseed);
    chk("busy_stage", bus.busy, 1);
    if (noisy) bus.fit_done = 1'b1;
    for (int k = 1; k <= d; k++) begin
      tick();
      if (noisy && k == 1) begin
        bus.fit_done = 1'b0;
        bus.mut_done = 1'b1;
        bus.run      = 1'b1;
        bus.seed_in  = $urandom;
      end
      if (noisy && k == 2) begin
        bus.mut_done = 1'b0;
        bus.run      = 1'b0;
      end
      chk("start_one_cycle", start_of(st), 0);
      chk("no_early_advance", next_of(st), 0);
      chk("no_error", bus.error, 0);
      if (k == d) set_done(st, 1'b1);
    end
    tick();
    set_done(st, 1'b0);
    if (st == 2) begin
      chk("pop_load", bus.pop_load, 1);
      chk("gen_before_commit", 32'(bus.generation), mgen);
      tick();
      mgen++;
      mseed = lfsr_next(mseed);
      chk("generation", 32'(bus.generation), mgen);
      chk("seed_step", bus.prg_seed, mseed);
      chk("pop_load_one_cycle", bus.pop_load, 0);
      if (mgen == NG) begin
        chk("done_rise", bus.done, 1);
        chk("busy_after_done", bus.busy, 0);
      end else begin
        chk("next_fit_start", bus.fit_start, 1);
      end
    end else begin
      chk("next_start", start_of(st + 1), 1);
    end
  endtask

  task automatic start_run(input logic [31:0] seed);
    bus.seed_in = seed;
    bus.run     = 1'b1;
    tick();
    bus.run = 1'b0;
    mseed   = (seed == 32'd0) ? 32'd1 : seed;
    mgen    = 0;
    chk("run_gen_clear", 32'(bus.generation), 0);
    chk("run_fit_start", bus.fit_start, 1);
    chk("run_seed_load", bus.prg_seed, mseed);
    chk("run_no_done", bus.done, 0);
  endtask

  task automatic full_run(input logic [31:0] seed, input bit fixed);
    int  d;
    bit  noisy;
    start_run(seed);
    for (int g = 0; g < int'(NG); g++) begin
      for (int st = 0; st < 3; st++) begin
        d     = fixed ? 5 : int'($urandom_range(3, 12));
        noisy = !fixed && (st == 0) && ($urandom_range(0, 1) == 1);
        stage(st, d, noisy);
      end
    end
    tick();
    chk("done_hold", bus.done, 1);
    chk("gen_hold", 32'(bus.generation), NG);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.run     = 1'b0;
    bus.abort   = 1'b0;
    bus.seed_in = '0;
    bus.fit_done = 1'b0;
    bus.sel_done = 1'b0;
    bus.mut_done = 1'b0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_gen", 32'(bus.generation), 0);
    chk("rst_seed", bus.prg_seed, 32'h1);
    chk("rst_fit_start", bus.fit_start, 0);
    chk("rst_pop_load", bus.pop_load, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", bus.busy, 0);

    // Happy path, zero seed, then randomized runs
    full_run(32'h0000ACE1, 1'b1);
    full_run(32'h0, 1'b0);
    for (int r = 0; r < 2; r++) full_run($urandom, 1'b0);

    // Stall in SEL: error exactly TO cycles after sel_start
    start_run($urandom);
    stage(0, int'($urandom_range(3, 12)), 1'b0);
    for (int k = 1; k < int'(TO); k++) begin
      tick();
      chk("stall_no_error", bus.error, 0);
      chk("stall_no_mut", bus.mut_start, 0);
    end
    tick();
    chk("stall_error", bus.error, 1);
    chk("stall_no_mut_final", bus.mut_start, 0);
    chk("stall_busy", bus.busy, 0);
    tick();
    chk("err_hold", bus.error, 1);

    // Restart from ERR, then abort during MUT of the second generation
    start_run($urandom);
    for (int st = 0; st < 3; st++) stage(st, int'($urandom_range(3, 12)), 1'b0);
    stage(0, 4, 1'b0);
    stage(1, 6, 1'b0);
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_pop", bus.pop_load, 0);
    chk("abort_gen", 32'(bus.generation), mgen);
    chk("abort_seed", bus.prg_seed, mseed);
    chk("abort_error", bus.error, 0);
    tick();
    bus.mut_done = 1'b1;
    tick();
    bus.mut_done = 1'b0;
    chk("late_mut_pop", bus.pop_load, 0);
    chk("late_mut_gen", 32'(bus.generation), mgen);
    chk("late_mut_fit", bus.fit_start, 0);
    tick();
    chk("late_mut_busy", bus.busy, 0);

    // Done coinciding with the timeout cycle wins; then reset mid-run
    start_run($urandom);
    stage(0, 4, 1'b0);
    stage(1, int'(TO) - 1, 1'b0);
    chk("done_wins_error", bus.error, 0);
    stage(2, 3, 1'b0);
    stage(0, 5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel_start", bus.sel_start, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_gen", 32'(bus.generation), 0);
    chk("arst_seed", bus.prg_seed, 32'h1);
    chk("arst_pop", bus.pop_load, 0);
    chk("arst_fit_start", bus.fit_start, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
